keypad_decode: RTL
==================

# keypad_decode

Debounces and encodes the 12-bit one-hot `key_data` produced by the keypad scanner into 4-bit key codes. Each debounced press yields exactly one event, queued in a small FIFO and presented on a valid/ready output. Sits directly downstream of the keypad scanner and feeds the application logic (digit entry, command FSMs).

## Interface
- `DEBOUNCE_CYCLES`, default 20000: `clk` cycles a code must stay stable to be accepted, on both press and release. Must be ≥1.
- `FIFO_DEPTH`, default 4: event queue depth. Power of two, ≥2.
- `REPEAT_CYCLES`, default 500000: auto-repeat period. Used only when `KEYPAD_DECODE_REPEAT_EN` is defined.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `key_data`, in, 12: one-hot from the scanner.
  - Bits 0–8: keys 1–9.
  - Bit 9: `*`.
  - Bit 10: `0`.
  - Bit 11: `#`.
- `key_code`, out, 4: FIFO head code. Valid only while `key_valid` is high.
- `key_valid`, out, 1: FIFO is non-empty.
- `key_ready`, in, 1: consumer accepts the head when `key_valid && key_ready`.
- `key_held`, out, 1: a debounced key is currently down.
- `key_overflow`, out, 1: one-cycle pulse when an accepted event is dropped because the FIFO is full.

## Operation
- **Input sampling:** `key_data` is registered once into `sample_q` and then mapped to a code:
  - One bit set: code = key value 0–9, `*`=0xA, `#`=0xB.
  - Zero bits set: KEY_NONE (0xF).
  - More than one bit set: treated as KEY_NONE.
- **FSM states:** IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. The FSM keeps a candidate register `cand` and a counter `cnt`.
- **IDLE:** if code ≠ NONE, set `cand`=code, `cnt`=0, go to PRESS_WAIT.
- **PRESS_WAIT:**
  - Code ≠ `cand`: return to IDLE. A different key restarts from IDLE on the next cycle.
  - Code = `cand` and `cnt`=DEBOUNCE_CYCLES−1: push `cand`, go to HELD.
  - Code = `cand` otherwise: `cnt`++.
- **HELD:** code ≠ `cand` (including NONE): `cnt`=0, go to RELEASE_WAIT.
- **RELEASE_WAIT:**
  - Code = `cand`: return to HELD. No new event.
  - Code ≠ `cand` and `cnt`=DEBOUNCE_CYCLES−1: go to IDLE.
  - Code ≠ `cand` otherwise: `cnt`++.
- **`key_held`:** high in HELD and RELEASE_WAIT.
- **FIFO behaviour:**
  - Push when not full: write the code.
  - Push when full with no pop in the same cycle: drop the new code, pulse `key_overflow`.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Pop when empty: ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- **Reset values:**
  - Outputs: `key_code`=0, `key_valid`=0, `key_held`=0, `key_overflow`=0.
  - Internal: FSM in IDLE, `cnt`=0, `cand`=0xF, FIFO empty.
- **Reset mid-operation:** discards queued and in-progress events. No event is produced from pre-reset input history.

## Timing
- Let edge N be the first edge at which `sample_q` holds the new code.
  - IDLE→PRESS_WAIT at N+1.
  - Push at N+DEBOUNCE_CYCLES+1.
  - `key_valid` high after that edge when the FIFO was empty.
- Pop takes effect at the edge where `key_valid && key_ready`. The next entry, if any, is visible after that edge. Back-to-back pops at one per cycle are allowed.
- `key_code` and `key_valid` are registered/FIFO-state outputs with no combinational path from `key_ready`.
- `cnt` width: $clog2 of the largest active cycle parameter.

## Configuration
- **`KEYPAD_DECODE_REPEAT_EN` defined:**
  - In HELD, a repeat counter increments every cycle.
  - At REPEAT_CYCLES−1 it pushes `cand` again and clears.
  - The repeat counter clears on entry to HELD. It keeps its value, without incrementing, in RELEASE_WAIT.
- **Undefined:** one event per press regardless of hold time, and REPEAT_CYCLES is ignored.

## Structure
- Package `keypad_pkg`:
  - Key code constants KEY_0…KEY_9, KEY_STAR=4'hA, KEY_HASH=4'hB, KEY_NONE=4'hF.
  - FSM state enum.
  - Shared with the application logic.
- Sub-module `key_fifo`: synchronous single-clock FIFO parameterised by width and depth, with push/pop/full/empty. The decode FSM and one-hot mapping stay in `keypad_decode`.

## Test plan
Test parameters: DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, `key_ready`=1 unless stated.
- `key_data`=0x010 held 12 cycles, then 0 → one transfer with `key_code`=5, `key_valid` after edge N+5, `key_held` high until release debounce completes.
- `key_data`=0x001 for 3 cycles, then 0 → no event, `key_held` stays 0.
- `key_data`=0x011 (two keys) for 20 cycles → no event.
- Hold 0x200, drop to 0 for 2 cycles, return to 0x200 for 10 cycles, then release → exactly one event with `key_code`=0xA.
- `key_ready`=0, five separate debounced presses of 0x001, 0x002, 0x004, 0x008, 0x010 → `key_overflow` pulses once on the 5th press. Then `key_ready`=1 drains 1, 2, 3, 4 on consecutive cycles, and `key_valid` falls.
- `rst` pulsed during PRESS_WAIT with 2 entries queued → after reset `key_valid`=0 and `key_held`=0. No event until a fresh full debounce completes.

Source files
------------

// File: rtl/keypad_pkg.sv
// Key code constants, debounce FSM states and the one-hot to key code mapping,
// shared between keypad_decode and the application logic.
package keypad_pkg;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } key_state_t;

  // Any pattern that is not exactly one bit (no key, or several keys) maps to KEY_NONE.
  function automatic logic [3:0] onehot_to_code(input logic [11:0] onehot);
    logic [3:0] code;
    code = KEY_NONE;
    case (onehot)
      12'h001: code = KEY_1;
      12'h002: code = KEY_2;
      12'h004: code = KEY_3;
      12'h008: code = KEY_4;
      12'h010: code = KEY_5;
      12'h020: code = KEY_6;
      12'h040: code = KEY_7;
      12'h080: code = KEY_8;
      12'h100: code = KEY_9;
      12'h200: code = KEY_STAR;
      12'h400: code = KEY_0;
      12'h800: code = KEY_HASH;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous single-clock FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate count.
module key_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/keypad_decode.sv
// Debounces the scanner's one-hot key_data into single key events queued in a FIFO.
// Define KEYPAD_DECODE_REPEAT_EN to re-emit the held key every REPEAT_CYCLES cycles.
module keypad_decode
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_CYCLES   = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] key_data,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ready,
  output logic        key_held,
  output logic        key_overflow
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("keypad_decode: illegal parameter value");
  end

`ifdef KEYPAD_DECODE_REPEAT_EN
  localparam int CNT_MAX = (REPEAT_CYCLES > DEBOUNCE_CYCLES) ? REPEAT_CYCLES : DEBOUNCE_CYCLES;
`else
  localparam int CNT_MAX = DEBOUNCE_CYCLES;
`endif
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [11:0]      sample_q;
  logic [3:0]       code;
  key_state_t       state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;

`ifdef KEYPAD_DECODE_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rep_q, rep_d;
`endif

  assign code = onehot_to_code(sample_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q     <= '0;
      state_q      <= ST_IDLE;
      cand_q       <= KEY_NONE;
      cnt_q        <= '0;
      key_overflow <= 1'b0;
    end else begin
      sample_q     <= key_data;
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      key_overflow <= push && fifo_full && !(key_ready && key_valid);
    end
  end

`ifdef KEYPAD_DECODE_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
`ifdef KEYPAD_DECODE_REPEAT_EN
    rep_d   = rep_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (code != KEY_NONE) begin
          cand_d  = code;
          cnt_d   = '0;
          state_d = ST_PRESS_WAIT;
        end
      end
      ST_PRESS_WAIT: begin
        if (code != cand_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          push    = 1'b1;
          state_d = ST_HELD;
`ifdef KEYPAD_DECODE_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (code != cand_q) begin
          cnt_d   = '0;
          state_d = ST_RELEASE_WAIT;
        end
`ifdef KEYPAD_DECODE_REPEAT_EN
        else if (rep_q == REP_LAST) begin
          push  = 1'b1;
          rep_d = '0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
`endif
      end
      ST_RELEASE_WAIT: begin
        // A bounce back to the same key resumes the hold without a new event.
        if (code == cand_q) begin
          state_d = ST_HELD;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign key_held  = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
  assign key_valid = !fifo_empty;

  key_fifo #(
    .WIDTH(4),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cand_q),
    .pop       (key_ready),
    .head      (key_code),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
